// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and defaults for the two-master data-memory
//               arbiter: FSM state enum, master index type, burst defaults
//               and a small index-to-one-hot helper.
// Revision    : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } arb_state_t;

  // Master 0 = CPU data port, master 1 = DMA/debug port.
  typedef logic [0:0] master_idx_t;

  localparam int unsigned BURST_MAX_DEFAULT = 4;
  localparam int unsigned BURST_CNT_W       = 4;

  function automatic logic [1:0] idx_to_onehot(input master_idx_t idx);
    return (idx == 1'b1) ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundle of the requester-side handshake signals and the
//               data-memory port of the arbiter.
//               slave  : arbiter view (takes requests, drives grants/memory)
//               master : environment view (requesters plus memory read data)
// Ports       : req/lock/we_m/a_m/wd_m  per-master request side
//               gnt/ack/rd_m            per-master response side
//               mem_we/mem_a/mem_wd     memory command, mem_rd memory data
// Revision    : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if;

  logic [1:0]       req;
  logic [1:0]       lock;
  logic [1:0]       we_m;
  logic [1:0][31:0] a_m;
  logic [1:0][31:0] wd_m;
  logic [1:0]       gnt;
  logic [1:0]       ack;
  logic [31:0]      rd_m;
  logic             mem_we;
  logic [31:0]      mem_a;
  logic [31:0]      mem_wd;
  logic [31:0]      mem_rd;

  modport slave (
    input  req, lock, we_m, a_m, wd_m, mem_rd,
    output gnt, ack, rd_m, mem_we, mem_a, mem_wd
  );

  modport master (
    output req, lock, we_m, a_m, wd_m, mem_rd,
    input  gnt, ack, rd_m, mem_we, mem_a, mem_wd
  );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin pick. A lone requester
//               wins; on a tie the master not granted most recently wins.
// Ports       : i_req     request vector
//               i_last    index of the most recently granted master
//               o_winner  selected master index
//               o_valid   at least one request present
// Revision    : 1.0  initial release
// ============================================================================
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0]  i_req,
  input  master_idx_t i_last,
  output master_idx_t o_winner,
  output logic        o_valid
);

  always_comb begin
    o_valid  = |i_req;
    o_winner = 1'b0;
    case (i_req)
      2'b01:   o_winner = 1'b0;
      2'b10:   o_winner = 1'b1;
      2'b11:   o_winner = ~i_last;
      default: o_winner = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-master data-memory arbiter with an IDLE/SERVE FSM,
//               round-robin tie break and bounded lock-based bursts.
//               One access is performed per SERVE cycle; the memory command
//               follows the owner's inputs combinationally.
// Ports       : clk    single clock
//               reset  synchronous active-high reset
//               bus    dmem_arbiter_if.slave (requests, grants, memory port)
// Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned BURST_MAX = BURST_MAX_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam logic [BURST_CNT_W-1:0] c_burst_max = BURST_CNT_W'(BURST_MAX);

  arb_state_t             r_state;
  master_idx_t            r_owner;
  master_idx_t            r_last;
  logic [BURST_CNT_W-1:0] r_cnt;
  logic [1:0]             r_gnt;

  master_idx_t w_winner;
  logic        w_valid;
  logic        w_serve;
  logic        w_hold;

  rr_pick2 u_pick (
    .i_req    (bus.req),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  assign w_serve = (r_state == SERVE);

  // Stay with the current owner only while it keeps lock and req asserted
  // and the burst has not yet used up its cycle allowance.
  assign w_hold = bus.lock[r_owner] & bus.req[r_owner] & (r_cnt < c_burst_max);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_gnt   <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state <= SERVE;
            r_owner <= w_winner;
            r_last  <= w_winner;
            r_cnt   <= BURST_CNT_W'(1);
            r_gnt   <= idx_to_onehot(w_winner);
          end
        end
        SERVE: begin
          if (w_hold) begin
            r_cnt <= r_cnt + BURST_CNT_W'(1);
          end else begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_gnt   <= 2'b00;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_gnt   <= 2'b00;
        end
      endcase
    end
  end

  // Reset in the middle of a SERVE cycle must suppress both the write
  // strobe and the completion strobe for that cycle.
  assign bus.mem_we = w_serve & bus.we_m[r_owner] & ~reset;
  assign bus.mem_a  = w_serve ? bus.a_m[r_owner]  : 32'h0;
  assign bus.mem_wd = w_serve ? bus.wd_m[r_owner] : 32'h0;
  assign bus.gnt    = r_gnt;
  assign bus.ack    = r_gnt & {2{~reset}};
  assign bus.rd_m   = (|bus.ack) ? bus.mem_rd : 32'h0;

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: BURST_MAX, 4, max consecutive SERVE cycles one master may hold via lock (range 1..15).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  [1:0]  access request per master; master 0 = CPU data port, master 1 = DMA/debug port.
REQ-005 lock  input  [1:0]  per-master burst-hold request, sampled only from the current owner.
REQ-006 we_m  input  [1:0]  per-master write enable.
REQ-007 a_m  input  [1:0][31:0]  per-master byte address.
REQ-008 wd_m  input  [1:0][31:0]  per-master write data.
REQ-009 gnt  output  [1:0]  one-hot owner indication; all zero in IDLE.
REQ-010 ack  output  [1:0]  one-hot completion strobe; high exactly in the cycle the access is performed.
REQ-011 rd_m  output  32  read data, equal to mem_rd whenever any ack bit is high, else 0.
REQ-012 mem_we, mem_a, mem_wd  output  1/32/32  data-memory port toward the RAM/peripheral map.
REQ-013 mem_rd  input  32  combinational read data returned by the data memory.

Function
REQ-014 FSM states SHALL be IDLE and SERVE only.
REQ-015 IDLE: if req nonzero, winner is latched into owner and FSM moves to SERVE next cycle; mem_we=0, mem_a=0, mem_wd=0, gnt=0, ack=0.
REQ-016 Single request: the requesting master SHALL win.
REQ-017 Both requesting: the master not granted most recently SHALL win (round-robin); last-granted resets to 1, so master 0 wins the first tie.
REQ-018 SERVE: mem_we/mem_a/mem_wd SHALL be driven combinationally from the owner's we_m/a_m/wd_m; gnt[owner]=1; ack[owner]=1; rd_m=mem_rd.
REQ-019 A write SHALL commit to memory at the clock edge ending the SERVE cycle; a read is valid in rd_m during that SERVE cycle.
REQ-020 Requesters SHALL hold req, we_m, a_m, wd_m stable from assertion until ack; the arbiter does not cancel an access whose req drops during SERVE.
REQ-021 End of SERVE: if lock[owner]=1 and req[owner]=1 and burst count < BURST_MAX, FSM SHALL stay in SERVE with the same owner (one access per cycle); otherwise it returns to IDLE.
REQ-022 Burst counter SHALL reset to 1 on entry to SERVE and increment per extra SERVE cycle; on reaching BURST_MAX the owner SHALL be released even with lock high.
REQ-023 last-granted SHALL update at every IDLE->SERVE transition.
REQ-024 Unlocked latency: request seen in IDLE at cycle N -> ack at cycle N+1; minimum spacing between unlocked accesses is 2 cycles.
REQ-025 A non-owner request raised during SERVE SHALL be held off and arbitrated at the next IDLE.

Reset
REQ-026 On reset: FSM=IDLE, owner=0, last-granted=1, burst count=0; gnt, ack, mem_we SHALL be 0 in the following cycle.
REQ-027 mem_we SHALL be gated by !reset so a reset asserted during SERVE performs no memory write at that edge and produces no ack.

Structure
REQ-028 Shared package dmem_arb_pkg SHALL hold the state enum (IDLE, SERVE), master-index typedef, and default BURST_MAX.
REQ-029 One sub-module rr_pick2 SHALL compute the winner from req and last-granted (purely combinational).

Verification
REQ-030 Reset then req=01, we_m[0]=1, a_m[0]=0x0000_0010, wd_m[0]=0xDEAD_BEEF -> ack[0] one cycle later, mem_we=1, RAM word 4 reads back 0xDEAD_BEEF.
REQ-031 req=11 held continuously, no lock -> grants alternate 0,1,0,1 with ack every 2nd cycle.
REQ-032 Master 1 req with lock=1 held, BURST_MAX=4, master 0 also requesting -> four consecutive ack[1] cycles, then IDLE, then ack[0].
REQ-033 Master 0 reads a_m[0]=0xC000_0004 with switches=0x2A5 -> rd_m=0x0000_02A5 while ack[0]=1.
REQ-034 reset pulsed during SERVE of a write to 0x0000_0020 -> no ack, memory word 8 unchanged, gnt=0 next cycle.
